// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
//
// Shared definitions for the asynchronous FIFO pointer/status blocks.
// Holds the default pointer geometry, the pointer typedef at that default
// width and the Gray->binary helper used by the conversion sub-module.
//
// Contents:
//   PTR_W_DEFAULT        pointer width (address bits + 1 wrap bit)
//   DEPTH_DEFAULT        FIFO depth implied by PTR_W_DEFAULT
//   SYNC_STAGES_DEFAULT  default synchronizer depth for the remote pointer
//   AF_THRESH_DEFAULT    default almost-full level
//   ptr_t                pointer type at the default width
//   depth_of()           depth implied by a given pointer width
//   gray2bin()           Gray -> binary conversion at the default width
// ---------------------------------------------------------------------------
package fifo_pkg;

    // Depth is half the pointer range: the extra top bit is the wrap bit
    // that lets a difference of DEPTH (full) be told apart from 0 (empty).
    function automatic int depth_of(input int ptr_w);
        return 2 ** (ptr_w - 1);
    endfunction

    localparam int PTR_W_DEFAULT       = 8;
    localparam int DEPTH_DEFAULT       = depth_of(PTR_W_DEFAULT);
    localparam int SYNC_STAGES_DEFAULT = 2;
    localparam int AF_THRESH_DEFAULT   = DEPTH_DEFAULT - 8;

    typedef logic [PTR_W_DEFAULT-1:0] ptr_t;

    // Each binary bit is the XOR of all Gray bits at and above it.
    function automatic ptr_t gray2bin(input ptr_t gray);
        ptr_t bin;
        bin = '0;
        for (int i = 0; i < PTR_W_DEFAULT; i++) begin
            bin[i] = ^(gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_to_binary.sv
// ---------------------------------------------------------------------------
// gray_to_binary
//
// Purely combinational Gray -> binary converter. Shared by the write-side
// and read-side status blocks so both convert synchronized pointers in
// exactly the same way.
//
// Parameters:
//   W     code width in bits
// Ports:
//   gray  input  [W-1:0]  Gray-coded value (already synchronized)
//   bin   output [W-1:0]  equivalent binary value
// ---------------------------------------------------------------------------
module gray_to_binary
    import fifo_pkg::*;
#(
    parameter int W = PTR_W_DEFAULT
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    // At the default pointer width the shared package helper is used
    // directly; other widths get the same prefix-XOR built bit by bit.
    if (W == PTR_W_DEFAULT) begin : g_pkg_width
        assign bin = gray2bin(gray);
    end else begin : g_any_width
        for (genvar i = 0; i < W; i++) begin : g_bit
            assign bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/wptr_full_sync.sv
// ---------------------------------------------------------------------------
// wptr_full_sync
//
// Write-side status block of an asynchronous FIFO. Brings the Gray-coded
// read pointer into the write clock domain, converts it to binary and
// computes the registered occupancy and full/almost-full flags, together
// with sticky overflow and pointer-corruption error flags.
//
// Parameters:
//   PTR_W        pointer width (address bits + 1 wrap bit)
//   SYNC_STAGES  synchronizer depth for remote_gray, 2..4
//   AF_THRESH    level at or above which almost_full asserts, 1..DEPTH
//
// Ports:
//   clk          input         write-domain clock
//   reset        input         asynchronous active-high reset
//   inc          input         write increment request this cycle
//   local_bin    input  [W]    registered binary write pointer
//   remote_gray  input  [W]    Gray read pointer, asynchronous to clk
//   err_clr      input         synchronous clear of the sticky errors
//   remote_bin   output [W]    synchronized read pointer in binary
//   level        output [W]    registered occupancy, 0..DEPTH
//   full         output        registered, level == DEPTH
//   almost_full  output        registered, level >= AF_THRESH
//   accepted     output        combinational, inc && !full
//   ovf_err      output        sticky, inc seen while full
//   ptr_err      output        sticky, computed level exceeded DEPTH
// ---------------------------------------------------------------------------
module wptr_full_sync
    import fifo_pkg::*;
#(
    parameter int PTR_W       = PTR_W_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter int AF_THRESH   = AF_THRESH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic [PTR_W-1:0] local_bin,
    input  logic [PTR_W-1:0] remote_gray,
    input  logic             err_clr,
    output logic [PTR_W-1:0] remote_bin,
    output logic [PTR_W-1:0] level,
    output logic             full,
    output logic             almost_full,
    output logic             accepted,
    output logic             ovf_err,
    output logic             ptr_err
);

    localparam int DEPTH = depth_of(PTR_W);

    // Thresholds widened by one bit so comparisons against DEPTH never
    // lose the top bit of the occupancy.
    localparam logic [PTR_W:0] DEPTH_EXT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] AF_EXT    = (PTR_W + 1)'(AF_THRESH);

    // Reject configurations the sync chain and flag logic were not built for.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("wptr_full_sync: SYNC_STAGES must be in 2..4");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("wptr_full_sync: AF_THRESH must be in 1..DEPTH");
    end

    logic [SYNC_STAGES-1:0][PTR_W-1:0] sync_q;
    logic [PTR_W-1:0]                  level_next;
    logic                              full_next;
    logic                              almost_full_next;
    logic                              corrupt_next;
    logic                              overflow_now;

    // Synchronizer for the remote Gray pointer. Only one bit changes per
    // remote step, so any metastable sample resolves to either the old or
    // the new pointer. Stages are plain flops with nothing in between so
    // each stage gets the full period to settle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], remote_gray};
        end
    end

    // Conversion happens only after the last stage; converting earlier
    // would let a multi-bit binary change be sampled mid-transition.
    gray_to_binary #(
        .W (PTR_W)
    ) u_remote_g2b (
        .gray (sync_q[SYNC_STAGES-1]),
        .bin  (remote_bin)
    );

    assign accepted = inc && !full;

    // Next occupancy and flags. Modulo subtraction handles pointer wrap on
    // its own; the wrap bit makes "full" a difference of exactly DEPTH.
    // Anything above DEPTH cannot happen with sane pointers and is reported
    // as corruption, while level still shows the raw computed value.
    always_comb begin
        level_next       = local_bin + {{(PTR_W-1){1'b0}}, accepted} - remote_bin;
        full_next        = ({1'b0, level_next} == DEPTH_EXT);
        almost_full_next = ({1'b0, level_next} >= AF_EXT);
        corrupt_next     = ({1'b0, level_next} > DEPTH_EXT);
        overflow_now     = inc && full;
    end

    // Occupancy and its derived flags share one register stage so they
    // always describe the same snapshot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level       <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            level       <= level_next;
            full        <= full_next;
            almost_full <= almost_full_next;
        end
    end

    // Sticky error flags. A new error in the same cycle as err_clr takes
    // priority so an event is never lost to a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_err <= 1'b0;
            ptr_err <= 1'b0;
        end else begin
            if (overflow_now) begin
                ovf_err <= 1'b1;
            end else if (err_clr) begin
                ovf_err <= 1'b0;
            end

            if (corrupt_next) begin
                ptr_err <= 1'b1;
            end else if (err_clr) begin
                ptr_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wptr_full_sync.sv
// ---------------------------------------------------------------------------
// tb_wptr_full_sync
//
// Directed bench for wptr_full_sync at its default parameters. The driver
// applies input vectors and queues the hand-computed outputs together with
// the cycle they become due; an independent monitor compares the DUT
// against every due entry on each falling edge.
// ---------------------------------------------------------------------------
module tb_wptr_full_sync;

    localparam int SEL_LEVEL = 0;
    localparam int SEL_FULL  = 1;
    localparam int SEL_AF    = 2;
    localparam int SEL_ACC   = 3;
    localparam int SEL_OVF   = 4;
    localparam int SEL_PERR  = 5;
    localparam int SEL_RBIN  = 6;

    typedef struct {
        int          due;
        int          sel;
        logic [31:0] value;
        string       name;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       inc = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] local_bin = 8'h00;
    logic [7:0] remote_gray = 8'h00;
    logic [7:0] remote_bin;
    logic [7:0] level;
    logic       full;
    logic       almost_full;
    logic       accepted;
    logic       ovf_err;
    logic       ptr_err;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    wptr_full_sync dut (
        .clk         (clk),
        .reset       (reset),
        .inc         (inc),
        .local_bin   (local_bin),
        .remote_gray (remote_gray),
        .err_clr     (err_clr),
        .remote_bin  (remote_bin),
        .level       (level),
        .full        (full),
        .almost_full (almost_full),
        .accepted    (accepted),
        .ovf_err     (ovf_err),
        .ptr_err     (ptr_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] get_actual(input int sel);
        case (sel)
            SEL_LEVEL: return 32'(level);
            SEL_FULL:  return 32'(full);
            SEL_AF:    return 32'(almost_full);
            SEL_ACC:   return 32'(accepted);
            SEL_OVF:   return 32'(ovf_err);
            SEL_PERR:  return 32'(ptr_err);
            SEL_RBIN:  return 32'(remote_bin);
            default:   return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Queue an expected output value, due 'delay' rising edges from now.
    task automatic expect_out(input int delay, input int sel,
                              input logic [31:0] value, input string name);
        exp_t e;
        e.due   = cyc + delay;
        e.sel   = sel;
        e.value = value;
        e.name  = name;
        sb.push_back(e);
    endtask

    task automatic check_output(input exp_t e);
        logic [31:0] act;
        act = get_actual(e.sel);
        checks++;
        if (act !== e.value) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)",
                     e.name, act, e.value, cyc);
        end
    endtask

    // Monitor: compare everything due this cycle, away from the rising edge.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                check_output(sb[i]);
                sb.delete(i);
            end
        end
    end

    task automatic apply_stimulus(input logic [7:0] lb, input logic [7:0] rg,
                                  input logic inc_v, input logic clr_v);
        @(posedge clk);
        #1;
        local_bin   = lb;
        remote_gray = rg;
        inc         = inc_v;
        err_clr     = clr_v;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic expect_reset_state(input string tag);
        expect_out(0, SEL_LEVEL, 32'h00, {tag, "_level"});
        expect_out(0, SEL_FULL,  32'h0,  {tag, "_full"});
        expect_out(0, SEL_AF,    32'h0,  {tag, "_af"});
        expect_out(0, SEL_OVF,   32'h0,  {tag, "_ovf"});
        expect_out(0, SEL_PERR,  32'h0,  {tag, "_perr"});
        expect_out(0, SEL_RBIN,  32'h00, {tag, "_rbin"});
    endtask

    initial begin
        // Held in reset with non-zero pointers: everything must stay zero.
        reset       = 1'b1;
        local_bin   = 8'h80;
        remote_gray = 8'h40;
        @(posedge clk);
        #1;
        expect_reset_state("rst");

        // Release with write pointer one full lap ahead.
        @(posedge clk);
        #1;
        reset       = 1'b0;
        remote_gray = 8'h00;
        expect_out(1, SEL_LEVEL, 32'h80, "full_level");
        expect_out(1, SEL_FULL,  32'h1,  "full_flag");
        expect_out(1, SEL_AF,    32'h1,  "full_af");

        // Increment while full is refused and flagged.
        apply_stimulus(8'h80, 8'h00, 1'b1, 1'b0);
        expect_out(0, SEL_ACC,   32'h0,  "acc_when_full");
        expect_out(1, SEL_OVF,   32'h1,  "ovf_set");
        expect_out(1, SEL_LEVEL, 32'h80, "ovf_level_held");

        // Clear and set together: set wins.
        apply_stimulus(8'h80, 8'h00, 1'b1, 1'b1);
        expect_out(1, SEL_OVF, 32'h1, "ovf_set_wins");

        apply_stimulus(8'h80, 8'h00, 1'b0, 1'b1);
        expect_out(0, SEL_ACC, 32'h0, "acc_no_inc");
        expect_out(1, SEL_OVF, 32'h0, "ovf_cleared");

        // Remote pointer catches up: Gray 0xC0 is binary 0x80.
        apply_stimulus(8'h80, 8'hC0, 1'b0, 1'b0);
        expect_out(1, SEL_RBIN,  32'h00, "rbin_sync_1edge");
        expect_out(2, SEL_RBIN,  32'h80, "rbin_sync_2edge");
        expect_out(2, SEL_LEVEL, 32'h80, "level_before_rbin");
        expect_out(2, SEL_FULL,  32'h1,  "full_before_rbin");
        expect_out(3, SEL_LEVEL, 32'h00, "empty_level");
        expect_out(3, SEL_FULL,  32'h0,  "empty_full");
        expect_out(3, SEL_AF,    32'h0,  "empty_af");
        idle(2);

        // Move both pointers to 0x85 (Gray 0xC7) to set up the wrap case.
        apply_stimulus(8'h85, 8'hC7, 1'b0, 1'b0);
        expect_out(1, SEL_LEVEL, 32'h05, "pre_wrap_level");
        expect_out(3, SEL_RBIN,  32'h85, "pre_wrap_rbin");
        expect_out(3, SEL_LEVEL, 32'h00, "pre_wrap_empty");
        idle(2);

        // Write pointer wraps to 0x05: 0x05 - 0x85 mod 256 = 128.
        apply_stimulus(8'h05, 8'hC7, 1'b0, 1'b0);
        expect_out(1, SEL_LEVEL, 32'h80, "wrap_level");
        expect_out(1, SEL_FULL,  32'h1,  "wrap_full");
        expect_out(1, SEL_PERR,  32'h0,  "wrap_no_perr");

        // Remote wraps to Gray 0x06 = binary 0x04: level 1.
        apply_stimulus(8'h05, 8'h06, 1'b0, 1'b0);
        expect_out(2, SEL_RBIN,  32'h04, "wrap_rbin");
        expect_out(2, SEL_LEVEL, 32'h80, "wrap_level_held");
        expect_out(3, SEL_LEVEL, 32'h01, "wrap_level_one");
        expect_out(3, SEL_FULL,  32'h0,  "wrap_not_full");
        idle(2);

        // Just below the almost-full threshold.
        apply_stimulus(8'h77, 8'h00, 1'b0, 1'b0);
        expect_out(1, SEL_LEVEL, 32'h73, "af_ramp_level");
        expect_out(3, SEL_LEVEL, 32'h77, "af_below_level");
        expect_out(3, SEL_AF,    32'h0,  "af_below");
        idle(2);

        // Accepted increment reaches the threshold exactly.
        apply_stimulus(8'h77, 8'h00, 1'b1, 1'b0);
        expect_out(0, SEL_ACC,   32'h1,  "acc_not_full");
        expect_out(1, SEL_LEVEL, 32'h78, "af_at_level");
        expect_out(1, SEL_AF,    32'h1,  "af_at");
        expect_out(1, SEL_FULL,  32'h0,  "af_at_not_full");

        // Corrupted pointer: level 144 > 128.
        apply_stimulus(8'h90, 8'h00, 1'b0, 1'b0);
        expect_out(1, SEL_PERR,  32'h1,  "perr_set");
        expect_out(1, SEL_LEVEL, 32'h90, "perr_level_raw");
        expect_out(1, SEL_FULL,  32'h0,  "perr_not_full");
        expect_out(1, SEL_AF,    32'h1,  "perr_af");

        apply_stimulus(8'h90, 8'h00, 1'b0, 1'b1);
        expect_out(1, SEL_PERR, 32'h1, "perr_set_wins");

        // Clear and build up level 50 against remote 4 (Gray 0x06).
        apply_stimulus(8'h36, 8'h06, 1'b0, 1'b1);
        expect_out(1, SEL_PERR,  32'h0,  "perr_cleared");
        expect_out(1, SEL_LEVEL, 32'h36, "mid_level_raw");
        expect_out(2, SEL_RBIN,  32'h04, "mid_rbin");
        expect_out(3, SEL_LEVEL, 32'h32, "mid_level_50");
        idle(3);

        // Asynchronous reset: zero before the next rising edge.
        @(posedge clk);
        #1;
        reset = 1'b1;
        expect_reset_state("async_rst");

        @(posedge clk);
        #1;
        reset = 1'b0;
        expect_out(1, SEL_RBIN,  32'h00, "resync_rbin_1");
        expect_out(1, SEL_LEVEL, 32'h36, "resync_level_1");
        expect_out(2, SEL_RBIN,  32'h04, "resync_rbin_2");
        expect_out(2, SEL_LEVEL, 32'h36, "resync_level_2");
        expect_out(3, SEL_LEVEL, 32'h32, "resync_level_3");

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            @(posedge clk);
        end
        @(negedge clk);
        #1;
        foreach (sb[i]) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: never checked, expected %0h due cycle %0d",
                     sb[i].name, sb[i].value, sb[i].due);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
